// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide engine feeding the HI/LO register file.
//   MULT/MULTU complete in one cycle, MTHI/MTLO merge the new half with the
//   current HI/LO, DIV/DIVU run a 32-iteration radix-2 restoring divider.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start, op, a, b     issue strobe (sampled when idle), opcode, operands
//   hi_cur, lo_cur      current HI/LO values for MTHI/MTLO merging
//   cancel              flush; aborts any operation, beats start
//   busy                divide in flight, pipeline must stall
//   hilo_we, hi_o, lo_o one-cycle HI/LO write strobe and write data
module muldiv_unit #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi_cur,
   input  logic [WIDTH-1:0] lo_cur,
   input  logic             cancel,
   output logic             busy,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
   localparam int unsigned PW    = 2 * WIDTH;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DIV_RUN = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic [1:0]       state, state_d;
   logic             busy_d, hilo_we_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [WIDTH-1:0] rem, rem_d;     // partial remainder
   logic [WIDTH-1:0] quo, quo_d;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvsr, dvsr_d;   // divisor magnitude
   logic             neg_q, neg_q_d;
   logic             neg_r, neg_r_d;

   logic             sgn;
   logic [PW-1:0]    prod_s, prod_u;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic [WIDTH-1:0] step_rem, step_quo;

   // Products: sign-extending to full width makes the low 2*WIDTH bits the signed product.
   always_comb begin
      prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   end

   // One restoring-division step; extra top bit of diff acts as the borrow flag.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, dvsr};
      if (!diff[WIDTH+1]) begin
         step_rem = diff[WIDTH-1:0];
         step_quo = {quo[WIDTH-2:0], 1'b1};
      end else begin
         step_rem = shifted[WIDTH-1:0];
         step_quo = {quo[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state, datapath and output logic.
   always_comb begin
      state_d   = state;
      busy_d    = busy;
      hilo_we_d = 1'b0;
      hi_d      = hi_o;
      lo_d      = lo_o;
      cnt_d     = cnt;
      rem_d     = rem;
      quo_d     = quo;
      dvsr_d    = dvsr;
      neg_q_d   = neg_q;
      neg_r_d   = neg_r;
      sgn       = 1'b0;

      case (state)
         ST_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               case (op)
                  OP_MULT: begin
                     hilo_we_d    = 1'b1;
                     {hi_d, lo_d} = prod_s;
                  end
                  OP_MULTU: begin
                     hilo_we_d    = 1'b1;
                     {hi_d, lo_d} = prod_u;
                  end
                  OP_MTHI: begin
                     hilo_we_d = 1'b1;
                     hi_d      = a;
                     lo_d      = lo_cur;
                  end
                  OP_MTLO: begin
                     hilo_we_d = 1'b1;
                     hi_d      = hi_cur;
                     lo_d      = a;
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero runs unsigned on the raw dividend so the
                     // divider itself yields LO=all ones and HI=a.
                     sgn     = (op == OP_DIV) && (b != '0);
                     state_d = ST_DIV_RUN;
                     busy_d  = 1'b1;
                     cnt_d   = '0;
                     rem_d   = '0;
                     quo_d   = (sgn && a[WIDTH-1]) ? -a : a;
                     dvsr_d  = (sgn && b[WIDTH-1]) ? -b : b;
                     neg_q_d = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_r_d = sgn && a[WIDTH-1];
                  end
                  default: ;
               endcase
            end
         end
         ST_DIV_RUN: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
               state_d   = ST_DONE;
               hilo_we_d = 1'b1;
               lo_d      = neg_q ? -step_quo : step_quo;
               hi_d      = neg_r ? -step_rem : step_rem;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // Flush wins over everything, including a write about to be produced.
      if (cancel) begin
         state_d   = ST_IDLE;
         busy_d    = 1'b0;
         hilo_we_d = 1'b0;
         hi_d      = hi_o;
         lo_d      = lo_o;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         hilo_we <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
      end else begin
         state   <= state_d;
         busy    <= busy_d;
         hilo_we <= hilo_we_d;
         hi_o    <= hi_d;
         lo_o    <= lo_d;
         cnt     <= cnt_d;
         rem     <= rem_d;
         quo     <= quo_d;
         dvsr    <= dvsr_d;
         neg_q   <= neg_q_d;
         neg_r   <= neg_r_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b, hi_cur, lo_cur;
   logic        cancel;
   logic        busy, hilo_we;
   logic [31:0] hi_o, lo_o;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32), .DIV_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi_cur(hi_cur), .lo_cur(lo_cur), .cancel(cancel),
      .busy(busy), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   // Drive one issue; returns 1 ns after the edge that sampled it.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Watch 40 cycles after a divide issue, recording busy and write activity.
   task automatic run_div(output int bcyc, output int wcnt, output int wcyc,
                          output logic [31:0] hi, output logic [31:0] lo);
      bcyc = 0; wcnt = 0; wcyc = 0; hi = '0; lo = '0;
      for (int c = 1; c <= 40; c++) begin
         if (busy) bcyc++;
         if (hilo_we) begin wcnt++; wcyc = c; hi = hi_o; lo = lo_o; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000;
      a = '0; b = '0; hi_cur = '0; lo_cur = '0;
      #3;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (hilo_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", hilo_we); end
      checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
      checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
      #19 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult;
      logic [2:0]  ops [3];
      logic [31:0] xa [3], xb [3], ehi [3], elo [3];
      ops[0] = 3'b000; xa[0] = 32'hFFFFFFFF; xb[0] = 32'h2; ehi[0] = 32'hFFFFFFFF; elo[0] = 32'hFFFFFFFE;
      ops[1] = 3'b001; xa[1] = 32'hFFFFFFFF; xb[1] = 32'h2; ehi[1] = 32'h00000001; elo[1] = 32'hFFFFFFFE;
      ops[2] = 3'b000; xa[2] = 32'h7FFFFFFF; xb[2] = 32'h7FFFFFFF; ehi[2] = 32'h3FFFFFFF; elo[2] = 32'h00000001;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], xa[i], xb[i]);
         checks++; if (hilo_we !== 1'b1) begin failures++; $display("FAIL mult%0d_we got=%b exp=1", i, hilo_we); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult%0d_busy got=%b exp=0", i, busy); end
         checks++; if (hi_o !== ehi[i]) begin failures++; $display("FAIL mult%0d_hi got=%h exp=%h", i, hi_o, ehi[i]); end
         checks++; if (lo_o !== elo[i]) begin failures++; $display("FAIL mult%0d_lo got=%h exp=%h", i, lo_o, elo[i]); end
         @(posedge clk); #1;
         checks++; if (hilo_we !== 1'b0) begin failures++; $display("FAIL mult%0d_we_drop got=%b exp=0", i, hilo_we); end
      end
   endtask

   task automatic test_mthi_mtlo;
      lo_cur = 32'hAABBCCDD; hi_cur = 32'h0;
      issue(3'b100, 32'h12345678, 32'h0);
      checks++; if (hilo_we !== 1'b1) begin failures++; $display("FAIL mthi_we got=%b exp=1", hilo_we); end
      checks++; if (hi_o !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi_o); end
      checks++; if (lo_o !== 32'hAABBCCDD) begin failures++; $display("FAIL mthi_lo got=%h exp=aabbccdd", lo_o); end
      hi_cur = 32'h55; lo_cur = 32'h0;
      issue(3'b101, 32'h1, 32'h0);
      checks++; if (hilo_we !== 1'b1) begin failures++; $display("FAIL mtlo_we got=%b exp=1", hilo_we); end
      checks++; if (hi_o !== 32'h55) begin failures++; $display("FAIL mtlo_hi got=%h exp=55", hi_o); end
      checks++; if (lo_o !== 32'h1) begin failures++; $display("FAIL mtlo_lo got=%h exp=1", lo_o); end
      @(posedge clk); #1;
      issue(3'b110, 32'h9, 32'h9);
      checks++; if (hilo_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reserved_op got we=%b busy=%b exp 0/0", hilo_we, busy); end
   endtask

   task automatic test_div;
      logic [2:0]  ops [8];
      logic [31:0] xa [8], xb [8], elo [8], ehi [8];
      int bc, wc, wy;
      logic [31:0] h, l;
      ops[0] = 3'b011; xa[0] = 32'd100;       xb[0] = 32'd7;         elo[0] = 32'h0000000E; ehi[0] = 32'h2;
      ops[1] = 3'b010; xa[1] = 32'hFFFFFFF9;  xb[1] = 32'd2;         elo[1] = 32'hFFFFFFFD; ehi[1] = 32'hFFFFFFFF;
      ops[2] = 3'b010; xa[2] = 32'h80000000;  xb[2] = 32'hFFFFFFFF;  elo[2] = 32'h80000000; ehi[2] = 32'h0;
      ops[3] = 3'b011; xa[3] = 32'h1234;      xb[3] = 32'h0;         elo[3] = 32'hFFFFFFFF; ehi[3] = 32'h1234;
      ops[4] = 3'b010; xa[4] = 32'hFFFFFFF9;  xb[4] = 32'h0;         elo[4] = 32'hFFFFFFFF; ehi[4] = 32'hFFFFFFF9;
      ops[5] = 3'b010; xa[5] = 32'd7;         xb[5] = 32'hFFFFFFFE;  elo[5] = 32'hFFFFFFFD; ehi[5] = 32'h1;
      ops[6] = 3'b011; xa[6] = 32'hFFFFFFFF;  xb[6] = 32'h10;        elo[6] = 32'h0FFFFFFF; ehi[6] = 32'hF;
      ops[7] = 3'b011; xa[7] = 32'hFFFFFFFF;  xb[7] = 32'h80000000;  elo[7] = 32'h1;        ehi[7] = 32'h7FFFFFFF;
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], xa[i], xb[i]);
         run_div(bc, wc, wy, h, l);
         checks++; if (bc != 33) begin failures++; $display("FAIL div%0d_busy_cycles got=%0d exp=33", i, bc); end
         checks++; if (wc != 1 || wy != 33) begin failures++; $display("FAIL div%0d_we got count=%0d cycle=%0d exp 1/33", i, wc, wy); end
         checks++; if (l !== elo[i]) begin failures++; $display("FAIL div%0d_lo got=%h exp=%h", i, l, elo[i]); end
         checks++; if (h !== ehi[i]) begin failures++; $display("FAIL div%0d_hi got=%h exp=%h", i, h, ehi[i]); end
      end
   endtask

   task automatic test_cancel;
      int bc, wc, wy, wsum;
      logic [31:0] h, l;
      issue(3'b011, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      cancel = 1'b1; op = 3'b011; a = 32'd9; b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      checks++; if (busy !== 1'b0 || hilo_we !== 1'b0) begin failures++; $display("FAIL cancel_mid got busy=%b we=%b exp 0/0", busy, hilo_we); end
      // start held one more cycle: accepted now
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
      wsum = 0; wy = 0; l = '0; h = '0;
      for (int c = 1; c <= 40; c++) begin
         if (hilo_we) begin wsum++; wy = c; h = hi_o; l = lo_o; end
         // extra starts while busy must be ignored
         start = (c == 5 || c == 6 || c == 20);
         op = 3'b001; a = 32'd4; b = 32'd4;
         @(posedge clk); #1;
      end
      start = 1'b0;
      checks++; if (wsum != 1 || wy != 33) begin failures++; $display("FAIL restart_we got count=%0d cycle=%0d exp 1/33", wsum, wy); end
      checks++; if (l !== 32'd3 || h !== 32'd0) begin failures++; $display("FAIL restart_result got lo=%h hi=%h exp 3/0", l, h); end
      // cancel arriving at the final iteration edge kills the write
      issue(3'b011, 32'd100, 32'd7);
      repeat (31) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      checks++; if (hilo_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL cancel_last got we=%b busy=%b exp 0/0", hilo_we, busy); end
      run_div(bc, wc, wy, h, l);
      checks++; if (wc != 0 || bc != 0) begin failures++; $display("FAIL cancel_last_after got we_count=%0d busy_cycles=%0d exp 0/0", wc, bc); end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(3'b011, 32'd100, 32'd7);
      n = 0;
      while (busy && n < 50) begin @(posedge clk); #1; n++; end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_timeout got busy=%b exp=0", busy); end
      issue(3'b001, 32'd3, 32'd5);
      checks++; if (hilo_we !== 1'b1 || lo_o !== 32'd15 || hi_o !== 32'd0) begin
         failures++; $display("FAIL b2b_mult got we=%b hi=%h lo=%h exp 1/0/f", hilo_we, hi_o, lo_o); end
   endtask

   task automatic test_async_reset;
      int bc, wc, wy;
      logic [31:0] h, l;
      issue(3'b011, 32'd100, 32'd7);
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || hilo_we !== 1'b0) begin failures++; $display("FAIL areset_ctrl got busy=%b we=%b exp 0/0", busy, hilo_we); end
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin failures++; $display("FAIL areset_data got hi=%h lo=%h exp 0/0", hi_o, lo_o); end
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (hilo_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL areset_idle got we=%b busy=%b exp 0/0", hilo_we, busy); end
      issue(3'b011, 32'd100, 32'd7);
      run_div(bc, wc, wy, h, l);
      checks++; if (bc != 33 || wc != 1 || wy != 33) begin failures++; $display("FAIL areset_div_timing got busy=%0d we=%0d at=%0d exp 33/1/33", bc, wc, wy); end
      checks++; if (l !== 32'hE || h !== 32'h2) begin failures++; $display("FAIL areset_div_result got lo=%h hi=%h exp e/2", l, h); end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_mthi_mtlo;
      test_div;
      test_cancel;
      test_back_to_back;
      test_async_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide engine that produces the HI/LO pair and write strobe consumed by the HI/LO register file.
- Handles MULT/MULTU in one cycle and DIV/DIVU as a 32-iteration radix-2 restoring divider.
- Handles MTHI/MTLO by merging the new half with the current HI/LO value.
- Asserts busy so the pipeline stalls while a divide is in flight; an exception flush aborts the operation.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- DIV_CYCLES, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (rst==0 resets)
- start  input  1  issue strobe, sampled when idle
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- a  input  32  rs operand / dividend / MTHI-MTLO source
- b  input  32  rt operand / divisor
- hi_cur  input  32  current HI register value
- lo_cur  input  32  current LO register value
- cancel  input  1  flush; aborts any operation
- busy  output  1  divide in progress; pipeline must stall
- hilo_we  output  1  one-cycle HI/LO write strobe
- hi_o  output  32  HI write data, valid while hilo_we=1
- lo_o  output  32  LO write data, valid while hilo_we=1

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy, hilo_we, hi_o, lo_o, iteration counter and internal datapath all 0.
- All outputs are registered.
- States: IDLE, DIV_RUN, DONE.
- IDLE, start=1, cancel=0, sampled at edge E0:
  - MULT/MULTU: after E0, hilo_we=1 for exactly one cycle. {hi_o,lo_o} = 64-bit signed/unsigned product. State stays IDLE; busy stays 0.
  - MTHI: after E0, hilo_we=1 for one cycle; hi_o=a, lo_o=lo_cur.
  - MTLO: after E0, hilo_we=1 for one cycle; hi_o=hi_cur, lo_o=a.
  - DIV/DIVU: after E0, state=DIV_RUN, busy=1, counter=0. For signed DIV, operand magnitudes and result signs are latched at E0.
  - Reserved op: ignored, no response.
- DIV_RUN: one quotient bit per edge, E1..E32. After E32, state=DONE, hilo_we=1, lo_o=quotient, hi_o=remainder, busy=1.
- DONE: after the next edge (E33), state=IDLE, hilo_we=0, busy=0. hi_o/lo_o hold their value.
- Totals: busy high for 33 cycles; HI/LO captures at E33. A start asserted in the cycle busy falls is accepted at that edge.
- start while busy=1 is ignored. The issuer holds start until busy=0.
- Signed result rules:
  - Quotient negated if sign(a)^sign(b).
  - Remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (b==0), both DIV and DIVU: full 33-cycle latency; LO=0xFFFFFFFF, HI=a.
- cancel=1 at any edge:
  - Next state IDLE; busy=0 and hilo_we=0 after that edge.
  - Any in-flight result is discarded.
  - A hilo_we pulse about to be produced (start in the same cycle, or DIV_RUN at E32) is suppressed.
  - cancel has priority over start.
- rst asserted mid-operation: immediate return to reset values; no write is produced.
- hilo_we is never high for more than one consecutive cycle per operation.

Test Plan:
- Reset → MULT a=0xFFFFFFFF, b=0x00000002 → next cycle hilo_we=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, busy=0. Same operands with MULTU → hi_o=0x00000001, lo_o=0xFFFFFFFE.
- DIVU a=100, b=7 → busy=1 for 33 cycles; hilo_we=1 only in cycle 33; lo_o=0x0000000E, hi_o=0x00000002.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo_o=0x80000000, hi_o=0. DIVU a=0x1234, b=0 → lo_o=0xFFFFFFFF, hi_o=0x1234.
- Divide in flight:
  - cancel at iteration 10 → busy=0 next cycle and no hilo_we.
  - New start (DIVU 9/3) in the same cycle as cancel → ignored.
  - Same start one cycle later → accepted; lo_o=3, hi_o=0 after 33 cycles.
  - Extra start pulses while busy → ignored; exactly one hilo_we.
- MTHI a=0x12345678, lo_cur=0xAABBCCDD → hilo_we pulse, hi_o=0x12345678, lo_o=0xAABBCCDD. MTLO a=0x1, hi_cur=0x55 → hi_o=0x55, lo_o=0x1.
- rst pulled low asynchronously (mid-cycle) during DIV_RUN iteration 20 → busy, hilo_we, hi_o, lo_o all 0 immediately. After release, DIVU 100/7 completes normally.
